// File: rtl/load_store_unit_if.sv
// Request, memory and response signals of the load/store unit.
// slave: the load/store unit itself; master: execute stage plus data memory.
interface load_store_unit_if #(
  parameter int ADDR_W = 10
);
  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_we;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              rsp_valid;
  logic [31:0]       rsp_data;
  logic              rsp_misaligned;
  logic              rsp_illegal;

  modport slave (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, mem_addr, mem_we, mem_wdata,
    output rsp_valid, rsp_data, rsp_misaligned, rsp_illegal
  );

  modport master (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, mem_addr, mem_we, mem_wdata,
    input  rsp_valid, rsp_data, rsp_misaligned, rsp_illegal
  );
endinterface

// File: rtl/load_store_unit.sv
// RISC-V load/store initiator for a word-wide memory with one-cycle registered read.
// Define MISALIGN_SPLIT_EN to split misaligned halfword/word accesses into two word accesses.
module load_store_unit #(
  parameter int ADDR_W = 10
) (
  input  logic             clock,
  input  logic             reset,
  load_store_unit_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_WAIT   = 3'd2,
    S_RESP   = 3'd3
`ifdef MISALIGN_SPLIT_EN
    ,
    S_ISSUE2 = 3'd4,
    S_WAIT2  = 3'd5
`endif
  } state_t;

  localparam logic [ADDR_W-1:0] ONE_WORD = {{(ADDR_W-1){1'b0}}, 1'b1};

  // Rotates a lane-replicated store word so that its low byte lands on lane 'off'.
  function automatic logic [31:0] rotl_lanes(input logic [31:0] d, input logic [1:0] off);
    logic [4:0] sh;
    sh = {off, 3'b000};
    return (d << sh) | (d >> (6'd32 - {1'b0, sh}));
  endfunction

  function automatic logic [31:0] extend_load(input logic [63:0] raw, input logic [1:0] off,
                                              input logic [2:0] f3);
    logic [31:0] sh;
    sh = 32'(raw >> {off, 3'b000});
    case (f3)
      3'b000:  extend_load = {{24{sh[7]}}, sh[7:0]};
      3'b001:  extend_load = {{16{sh[15]}}, sh[15:0]};
      3'b010:  extend_load = sh;
      3'b100:  extend_load = {24'h000000, sh[7:0]};
      3'b101:  extend_load = {16'h0000, sh[15:0]};
      default: extend_load = 32'h0000_0000;
    endcase
  endfunction

  state_t            state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic              store_q, store_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [1:0]        off_q, off_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]        mem_we_q, mem_we_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_data_q, rsp_data_d;
  logic              rsp_mis_q, rsp_mis_d;
  logic              rsp_ill_q, rsp_ill_d;
`ifdef MISALIGN_SPLIT_EN
  logic              split_q, split_d;
  logic [3:0]        we_hi_q, we_hi_d;
  logic [31:0]       lo_q, lo_d;
  logic [7:0]        mask8_s;
`endif

  logic        illegal_s;
  logic        misaligned_s;
  logic [1:0]  off_s;
  logic [3:0]  size_mask_s;
  logic [3:0]  we_lo_s;
  logic [31:0] rep_s;

  // Decode the incoming request: faults, lane mask and replicated store data.
  always_comb begin
    off_s     = bus.req_addr[1:0];
    illegal_s = (bus.req_store && bus.req_funct3[2]) || (bus.req_funct3 == 3'b011) ||
                (bus.req_funct3 == 3'b110) || (bus.req_funct3 == 3'b111);
    case (bus.req_funct3[1:0])
      2'b00: begin
        misaligned_s = 1'b0;
        size_mask_s  = 4'b0001;
        rep_s        = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        misaligned_s = off_s[0];
        size_mask_s  = 4'b0011;
        rep_s        = {2{bus.req_wdata[15:0]}};
      end
      2'b10: begin
        misaligned_s = (off_s != 2'b00);
        size_mask_s  = 4'b1111;
        rep_s        = bus.req_wdata;
      end
      default: begin
        misaligned_s = 1'b0;
        size_mask_s  = 4'b0000;
        rep_s        = bus.req_wdata;
      end
    endcase
`ifdef MISALIGN_SPLIT_EN
    mask8_s = {4'b0000, size_mask_s} << off_s;
    we_lo_s = mask8_s[3:0];
`else
    we_lo_s = size_mask_s << off_s;
`endif
  end

  // Next-state and next-output logic; every output is loaded for the state being entered.
  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    store_d     = store_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 4'b0000;
    mem_wdata_d = mem_wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_mis_d   = rsp_mis_q;
    rsp_ill_d   = rsp_ill_q;
`ifdef MISALIGN_SPLIT_EN
    split_d     = split_q;
    we_hi_d     = we_hi_q;
    lo_d        = lo_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid && req_ready_q) begin
          store_d     = bus.req_store;
          funct3_d    = bus.req_funct3;
          off_d       = off_s;
          req_ready_d = 1'b0;
`ifdef MISALIGN_SPLIT_EN
          split_d     = misaligned_s;
          we_hi_d     = bus.req_store ? mask8_s[7:4] : 4'b0000;
`endif
          if (illegal_s) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_ill_d   = 1'b1;
          end
`ifndef MISALIGN_SPLIT_EN
          else if (misaligned_s) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_mis_d   = 1'b1;
          end
`endif
          else begin
            state_d     = S_ISSUE;
            mem_addr_d  = bus.req_addr[ADDR_W+1:2];
            mem_we_d    = bus.req_store ? we_lo_s : 4'b0000;
            mem_wdata_d = bus.req_store ? rotl_lanes(rep_s, off_s) : mem_wdata_q;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
`ifdef MISALIGN_SPLIT_EN
        if (split_q && store_q) begin
          state_d    = S_ISSUE2;
          mem_addr_d = mem_addr_q + ONE_WORD;
          mem_we_d   = we_hi_q;
        end else
`endif
        if (store_q) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
`ifdef MISALIGN_SPLIT_EN
        if (split_q) begin
          lo_d       = bus.mem_rdata;
          state_d    = S_ISSUE2;
          mem_addr_d = mem_addr_q + ONE_WORD;
        end else begin
`else
        begin
`endif
          rsp_data_d  = extend_load({32'h0000_0000, bus.mem_rdata}, off_q, funct3_q);
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end
      end
`ifdef MISALIGN_SPLIT_EN
      S_ISSUE2: begin
        if (store_q) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
        end else begin
          state_d = S_WAIT2;
        end
      end
      S_WAIT2: begin
        rsp_data_d  = extend_load({bus.mem_rdata, lo_q}, off_q, funct3_q);
        rsp_valid_d = 1'b1;
        state_d     = S_RESP;
      end
`endif
      S_RESP: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
        rsp_valid_d = 1'b0;
        rsp_data_d  = 32'h0000_0000;
        rsp_mis_d   = 1'b0;
        rsp_ill_d   = 1'b0;
      end
      default: begin
        state_d     = S_IDLE;
        req_ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers; reset abandons any request in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b1;
      store_q     <= 1'b0;
      funct3_q    <= 3'b000;
      off_q       <= 2'b00;
      mem_addr_q  <= '0;
      mem_we_q    <= 4'b0000;
      mem_wdata_q <= 32'h0000_0000;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'h0000_0000;
      rsp_mis_q   <= 1'b0;
      rsp_ill_q   <= 1'b0;
`ifdef MISALIGN_SPLIT_EN
      split_q     <= 1'b0;
      we_hi_q     <= 4'b0000;
      lo_q        <= 32'h0000_0000;
`endif
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      store_q     <= store_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_mis_q   <= rsp_mis_d;
      rsp_ill_q   <= rsp_ill_d;
`ifdef MISALIGN_SPLIT_EN
      split_q     <= split_d;
      we_hi_q     <= we_hi_d;
      lo_q        <= lo_d;
`endif
    end
  end

  assign bus.req_ready      = req_ready_q;
  assign bus.mem_addr       = mem_addr_q;
  assign bus.mem_we         = mem_we_q;
  assign bus.mem_wdata      = mem_wdata_q;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_data       = rsp_data_q;
  assign bus.rsp_misaligned = rsp_mis_q;
  assign bus.rsp_illegal    = rsp_ill_q;

endmodule
